// File: rtl/fpadd_share_sched.sv
// Round-robin scheduler sharing one FP adder between two requesters.
// One op in flight: accept -> wait ADD_LAT cycles -> hold result until taken.
module fpadd_share_sched #(
  parameter int W       = 32,
  parameter int ADD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_res,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_res,
  output logic         busy
);
  localparam int CW = $clog2(ADD_LAT + 1);

  generate
    if (ADD_LAT < 1) begin : g_lat_chk
      $error("fpadd_share_sched: ADD_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                owner, last_grant, grant, accept, rsp_take;
  logic [CW-1:0]       cnt;
  logic [1:0]          req_vld;
  logic [1:0][W-1:0]   req_a, req_b;

  assign req_vld = {req1_valid, req0_valid};
  assign req_a   = {req1_a, req0_a};
  assign req_b   = {req1_b, req0_b};

  // On a tie the requester that did not win last time goes next.
  assign grant    = (&req_vld) ? ~last_grant : req_vld[1];
  assign accept   = (state == IDLE) && (|req_vld);
  assign rsp_take = owner ? rsp1_ready : rsp0_ready;

  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) &&  grant && req1_valid;
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == CW'(1)) state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      add_a      <= '0;
      add_b      <= '0;
      rsp_res    <= '0;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        add_a      <= req_a[grant];
        add_b      <= req_b[grant];
        owner      <= grant;
        last_grant <= grant;
        cnt        <= CW'(ADD_LAT);
      end
      if (state == WAIT) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) rsp_res <= add_res;
      end
    end
  end
endmodule

// File: tb/tb_fpadd_share_sched.sv
// Bench for fpadd_share_sched: vector table, scoreboard, and corner sequences.
module tb_fpadd_share_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0] rsp_res, add_a, add_b, add_res;

  logic        c_req0_valid = 1'b0, c_req1_valid = 1'b0;
  logic        c_req0_ready, c_req1_ready, c_rsp0_valid, c_rsp1_valid, c_busy;
  logic        c_rsp0_ready = 1'b1, c_rsp1_ready = 1'b1;
  logic [31:0] c_req0_a = '0, c_req0_b = '0, c_req1_a = '0, c_req1_b = '0;
  logic [31:0] c_rsp_res, c_add_a, c_add_b, c_add_res;

  int pass_cnt = 0, tot_cnt = 0, cyc = 0;

  typedef struct {
    bit          id;
    logic [31:0] a, b, exp;
  } vec_t;
  typedef struct packed {
    logic        id;
    logic [31:0] res;
  } sb_t;
  sb_t sbq[$];

  function automatic logic [31:0] stub(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
  endfunction

  assign add_res   = stub(add_a, add_b);
  assign c_add_res = stub(c_add_a, c_add_b);

  fpadd_share_sched #(.W(32), .ADD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .add_a(add_a), .add_b(add_b), .add_res(add_res), .busy(busy)
  );

  fpadd_share_sched #(.W(32), .ADD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(c_req0_valid), .req0_ready(c_req0_ready), .req0_a(c_req0_a), .req0_b(c_req0_b),
    .rsp0_valid(c_rsp0_valid), .rsp0_ready(c_rsp0_ready),
    .req1_valid(c_req1_valid), .req1_ready(c_req1_ready), .req1_a(c_req1_a), .req1_b(c_req1_b),
    .rsp1_valid(c_rsp1_valid), .rsp1_ready(c_rsp1_ready),
    .rsp_res(c_rsp_res), .add_a(c_add_a), .add_b(c_add_b), .add_res(c_add_res), .busy(c_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Scoreboard on u1: push the adder's sum at accept, pop at response handshake.
  always @(negedge clk) begin
    if (!rst_n) sbq.delete();
    else begin
      if (req0_valid && req0_ready) sbq.push_back({1'b0, stub(req0_a, req0_b)});
      if (req1_valid && req1_ready) sbq.push_back({1'b1, stub(req1_a, req1_b)});
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sbq.size() == 0) begin
          tot_cnt++;
          $display("FAIL sb_unexpected: rsp0_valid=%0b rsp1_valid=%0b with nothing outstanding",
                   rsp0_valid, rsp1_valid);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("sb_owner", 32'(rsp1_valid), 32'(e.id));
          chk("sb_res", rsp_res, e.res);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = !busy; end
    if (!ok) chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int t0;
    bit ok;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = id ? req1_ready : req0_ready;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    t0 = cyc;
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = id ? rsp1_valid : rsp0_valid;
    end
    if (!ok) begin chk("rsp_timeout", 0, 1); return; end
    chk("latency", 32'(cyc - t0), 2);
    chk("rsp_res", rsp_res, exp);
    chk("other_rsp_valid", 32'(id ? rsp0_valid : rsp1_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   g[$];
    bit   ok, seen;
    int   t0;
    vecs[0] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[1] = '{1'b1, 32'h00000010, 32'h00000020, 32'h00000030};
    vecs[2] = '{1'b0, 32'h12345678, 32'h11111111, 32'h23456789};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[4] = '{1'b0, 32'h7F800000, 32'h00000001, 32'h7F800001};
    vecs[5] = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000};

    // reset state
    @(negedge clk);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 0);
    chk("rst_busy_lat3", 32'(c_busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vecs[k]) do_op(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].exp);
    wait_idle();

    // both requesters held valid from reset: strict alternation starting at 0
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'd1;   req0_b = 32'd2;
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd200;
    for (int i = 0; i < 60 && g.size() < 4; i++) begin
      @(negedge clk);
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_grant_count", 32'(g.size()), 4);
    for (int k = 0; k < g.size() && k < 4; k++) chk("tie_grant_order", 32'(g[k]), 32'(k % 2));
    wait_idle();

    // response stall blocks the other requester
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = req0_ready; end
    chk("stall_accept0", 32'(ok), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd8;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = rsp0_valid; end
    chk("stall_rsp0_valid", 32'(ok), 1);
    chk("stall_res", rsp_res, 32'd11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req1_ready", 32'(req1_ready), 0);
      chk("stall_res_hold", rsp_res, 32'd11);
    end
    @(posedge clk); #1 rsp0_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_still_resp", 32'(req1_ready), 0);
    @(negedge clk);
    chk("stall_req1_accept", 32'(req1_ready), 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_idle();

    // reset while waiting on the adder aborts the op
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = req0_ready; end
    chk("abort_accept", 32'(ok), 1);
    @(posedge clk); #1 req0_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy_wait", 32'(busy), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); seen |= rsp0_valid | rsp1_valid; end
    chk("abort_no_rsp", 32'(seen | rsp0_valid), 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd22;
    req1_valid = 1'b1; req1_a = 32'd30; req1_b = 32'd33;
    @(negedge clk);
    chk("abort_tie_req0", 32'({req1_ready, req0_ready}), 32'b01);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // only requester 1 active right after reset
    do_reset();
    do_op(1'b1, 32'd3, 32'd4, 32'd7);
    do_op(1'b1, 32'h100, 32'h200, 32'h300);
    do_op(1'b1, 32'hA, 32'hB, 32'h15);

    // ADD_LAT=3 instance: operands held 3 cycles, response at T+4
    @(posedge clk); #1;
    c_req1_valid = 1'b1; c_req1_a = 32'h11; c_req1_b = 32'h22;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = c_req1_ready; end
    chk("lat3_accept", 32'(ok), 1);
    t0 = cyc;
    @(posedge clk); #1;
    c_req1_valid = 1'b0; c_req1_a = 32'hDEAD; c_req1_b = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat3_add_a", c_add_a, 32'h11);
      chk("lat3_add_b", c_add_b, 32'h22);
      chk("lat3_early_rsp", 32'(c_rsp1_valid), 0);
    end
    @(negedge clk);
    chk("lat3_rsp1_valid", 32'(c_rsp1_valid), 1);
    chk("lat3_latency", 32'(cyc - t0), 4);
    chk("lat3_res", c_rsp_res, 32'h33);
    chk("lat3_rsp0_valid", 32'(c_rsp0_valid), 0);

    wait_idle();
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
